timer_cmp: RTL

Parametrised successor to the free-running microsecond timer.
- Generates a tick at TICK_FREQ from CPU_CLOCK_FREQ through a prescaler.
- Keeps a CNT_W-bit tick counter that software can read and load.
- Adds NUM_CH compare channels, each one-shot or periodic, with a pending flag and an interrupt output.
- Sits on the CPU memory-mapped IO bus beside the UART and other io_circuits, and feeds the interrupt controller.

---
 rtl/timer_pkg.sv | 31 +++
 rtl/timer_channel.sv | 76 +++++++
 rtl/timer_cmp.sv | 136 +++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register map, control bit positions and divider helpers for timer_cmp
package timer_pkg;

   localparam logic [7:0] COUNT_LO  = 8'd0;
   localparam logic [7:0] COUNT_HI  = 8'd1;
   localparam logic [7:0] CTRL      = 8'd2;
   localparam logic [7:0] PENDING   = 8'd3;
   localparam logic [7:0] CH_BASE   = 8'd4;
   localparam logic [7:0] CH_STRIDE = 8'd4;

   typedef enum logic [1:0] {
      CMP_LO  = 2'd0,
      CMP_HI  = 2'd1,
      CH_CTRL = 2'd2,
      PERIOD  = 2'd3
   } ch_reg_e;

   localparam int CTRL_RUN    = 0;
   localparam int CH_EN       = 0;
   localparam int CH_PERIODIC = 1;
   localparam int CH_IRQ_EN   = 2;

   function automatic int calc_div(input longint cpu_hz, input longint tick_hz);
      return (tick_hz > 0) ? int'(cpu_hz / tick_hz) : 0;
   endfunction

   function automatic bit div_exact(input longint cpu_hz, input longint tick_hz);
      return (tick_hz > 0) && ((cpu_hz % tick_hz) == 0);
   endfunction

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one compare channel: cmp, period, control bits and pending flag
module timer_channel
   import timer_pkg::*;
#(
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic [CNT_W-1:0] count_next,
   input  logic             wr,
   input  ch_reg_e          off,
   input  logic [31:0]      wdata,
   input  logic             w1c,
   output logic             pending,
   output logic             irq,
   output logic [31:0]      rdata
);

   logic [CNT_W-1:0] cmp;
   logic [31:0]      period;
   logic             en;
   logic             periodic;
   logic             irq_en;
   logic             hit;

   assign hit = en && tick && (count_next == cmp);
   assign irq = pending && irq_en;

   // Software writes come last so they override the hit update of the same field.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmp      <= '0;
         period   <= '0;
         en       <= 1'b0;
         periodic <= 1'b0;
         irq_en   <= 1'b0;
         pending  <= 1'b0;
      end else begin
         if (hit) begin
            pending <= 1'b1;
            if (periodic) cmp <= cmp + CNT_W'(period);
            else          en  <= 1'b0;
         end else if (w1c) begin
            pending <= 1'b0;
         end
         if (wr) begin
            case (off)
               CMP_LO:  cmp[31:0]       <= wdata;
               CMP_HI:  cmp[CNT_W-1:32] <= wdata[CNT_W-33:0];
               CH_CTRL: begin
                  en       <= wdata[CH_EN];
                  periodic <= wdata[CH_PERIODIC];
                  irq_en   <= wdata[CH_IRQ_EN];
               end
               PERIOD:  period <= wdata;
            endcase
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (off)
         CMP_LO:  rdata = cmp[31:0];
         CMP_HI:  rdata = 32'(cmp[CNT_W-1:32]);
         CH_CTRL: begin
            rdata[CH_EN]       = en;
            rdata[CH_PERIODIC] = periodic;
            rdata[CH_IRQ_EN]   = irq_en;
         end
         PERIOD:  rdata = period;
      endcase
   end

endmodule

// File: rtl/timer_cmp.sv
// rtl/timer_cmp.sv - prescaled tick counter with compare channels on the memory-mapped IO bus
module timer_cmp
   import timer_pkg::*;
#(
   parameter int CPU_CLOCK_FREQ = 50_000_000,
   parameter int TICK_FREQ      = 1_000_000,
   parameter int NUM_CH         = 4,
   parameter int CNT_W          = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic              wr_en,
   input  logic [7:0]        addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic [CNT_W-1:0]  count,
   output logic [NUM_CH-1:0] irq,
   output logic              irq_any
);

   localparam int DIV  = calc_div(CPU_CLOCK_FREQ, TICK_FREQ);
   localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int HI_W = CNT_W - 32;

   if (DIV < 1 || !div_exact(CPU_CLOCK_FREQ, TICK_FREQ)) begin : g_bad_div
      $error("timer_cmp: CPU_CLOCK_FREQ must be a positive integer multiple of TICK_FREQ");
   end
   if (NUM_CH < 1 || NUM_CH > 62 || CNT_W < 33 || CNT_W > 64) begin : g_bad_size
      $error("timer_cmp: NUM_CH must be 1..62 and CNT_W 33..64");
   end

   logic [PS_W-1:0]   presc;
   logic              run;
   logic              tick;
   logic              ch_tick;
   logic              cnt_wr_lo;
   logic              cnt_wr_hi;
   logic              cnt_wr;
   logic              pend_wr;
   logic [HI_W-1:0]   hi_shadow;
   logic [CNT_W-1:0]  count_next;
   logic [7:0]        ch_rel;
   logic [7:0]        ch_idx;
   ch_reg_e           ch_off;
   logic              ch_sel;
   logic [NUM_CH-1:0] pending;
   logic [31:0]       ch_rdata [NUM_CH];
   logic [31:0]       ch_rd;
   logic [31:0]       pend_rd;

   assign tick       = run && (presc == PS_W'(DIV - 1));
   assign cnt_wr_lo  = wr_en && (addr == COUNT_LO);
   assign cnt_wr_hi  = wr_en && (addr == COUNT_HI);
   assign cnt_wr     = cnt_wr_lo || cnt_wr_hi;
   assign pend_wr    = wr_en && (addr == PENDING);
   // A software load suppresses both the increment and any compare hit.
   assign ch_tick    = tick && !cnt_wr;
   assign count_next = count + 1'b1;

   assign ch_rel = addr - CH_BASE;
   assign ch_idx = ch_rel / CH_STRIDE;
   assign ch_off = ch_reg_e'(ch_rel[1:0]);
   assign ch_sel = (addr >= CH_BASE) && (ch_idx < 8'(NUM_CH));

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         presc <= '0;
         run   <= 1'b1;
      end else begin
         if (cnt_wr || tick) presc <= '0;
         else if (run)       presc <= presc + 1'b1;
         if (cnt_wr_lo) count[31:0]       <= wdata;
         if (cnt_wr_hi) count[CNT_W-1:32] <= wdata[HI_W-1:0];
         if (ch_tick)   count             <= count_next;
         if (wr_en && (addr == CTRL)) run <= wdata[CTRL_RUN];
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic ch_w1c;
      if (c < 32) begin : g_w1c
         assign ch_w1c = pend_wr && wdata[c];
      end else begin : g_no_w1c
         assign ch_w1c = 1'b0;
      end

      timer_channel #(.CNT_W(CNT_W)) u_ch (
         .clk        (clk),
         .rst        (rst),
         .tick       (ch_tick),
         .count_next (count_next),
         .wr         (wr_en && ch_sel && (ch_idx == 8'(c))),
         .off        (ch_off),
         .wdata      (wdata),
         .w1c        (ch_w1c),
         .pending    (pending[c]),
         .irq        (irq[c]),
         .rdata      (ch_rdata[c])
      );
   end

   assign irq_any = |irq;

   always_comb begin
      ch_rd   = '0;
      pend_rd = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_sel && (ch_idx == 8'(c))) ch_rd = ch_rdata[c];
      end
      for (int c = 0; c < NUM_CH && c < 32; c++) pend_rd[c] = pending[c];
   end

   // The LO read snapshots the upper half so a following HI read is tear-free.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata     <= '0;
         hi_shadow <= '0;
      end else if (rd_en) begin
         if (addr == COUNT_LO) begin
            rdata     <= count[31:0];
            hi_shadow <= count[CNT_W-1:32];
         end else if (addr == COUNT_HI) begin
            rdata <= 32'(hi_shadow);
         end else if (addr == CTRL) begin
            rdata <= {31'b0, run};
         end else if (addr == PENDING) begin
            rdata <= pend_rd;
         end else begin
            rdata <= ch_rd;
         end
      end
   end

endmodule
